// File: rtl/seq_pkg.sv
// Shared constants and state encoding for the serial 1011 stimulus source.
// Holds the tracked pattern, default widths and the transmitter FSM states.
package seq_pkg;
    localparam int PAT_LEN = 4;
    localparam logic [PAT_LEN-1:0] PATTERN = 4'b1011;

    localparam int DEF_W     = 16;
    localparam int DEF_LEN_W = 5;
    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/pattern_tracker.sv
// Golden Mealy model of overlapping PATTERN detection on a gapped bit stream.
// match is combinational on the current bit; count saturates instead of wrapping.
module pattern_tracker
    import seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             match,
    output logic [CNT_W-1:0] count
);
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign match = bit_valid && ({hist_q, bit_in} == PATTERN);
    assign count = cnt_q;

    // History only advances on valid bits, so idle gaps keep the pattern alive.
    always_comb begin
        hist_d = hist_q;
        cnt_d  = cnt_q;
        if (bit_valid) begin
            hist_d = {hist_q[PAT_LEN-3:0], bit_in};
        end
        if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/sequence_transmitter.sv
// Shifts the low len bits of data out MSB-first on x, first bit one cycle after load.
// Loads arriving while busy are dropped; expect_y/match_cnt come from the embedded tracker.
module sequence_transmitter
    import seq_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [W-1:0]     data,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             x,
    output logic             x_valid,
    output logic             done,
    output logic             expect_y,
    output logic [CNT_W-1:0] match_cnt
);
    state_t           state_q, state_d;
    logic [W-1:0]     shreg_q, shreg_d;
    logic [LEN_W-1:0] bitcnt_q, bitcnt_d;
    logic [LEN_W-1:0] len_eff;
    logic             accept;
    logic             last_bit;

    assign len_eff  = (len > LEN_W'(W)) ? LEN_W'(W) : len;
    assign accept   = (state_q == IDLE) && load && (len != '0);
    assign last_bit = (bitcnt_q == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Left-align the frame so the MSB of the shift register is always the next bit.
    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        if (accept) begin
            shreg_d  = data << (LEN_W'(W) - len_eff);
            bitcnt_d = len_eff;
        end else if (state_q == SHIFT) begin
            shreg_d  = {shreg_q[W-2:0], 1'b0};
            bitcnt_d = bitcnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    always_comb begin
        busy    = 1'b0;
        x       = 1'b0;
        x_valid = 1'b0;
        done    = 1'b0;
        if (state_q == SHIFT) begin
            busy    = 1'b1;
            x       = shreg_q[W-1];
            x_valid = 1'b1;
            done    = last_bit;
        end
    end

    pattern_tracker #(
        .CNT_W(CNT_W)
    ) u_tracker (
        .clk      (clk),
        .reset    (reset),
        .bit_in   (x),
        .bit_valid(x_valid),
        .match    (expect_y),
        .count    (match_cnt)
    );
endmodule

// File: tb/tb_sequence_transmitter.sv
// Scoreboard bench: the stimulus side predicts every emitted bit from a bit-stream model;
// a negedge monitor pops and compares whenever x_valid is seen.
module tb_sequence_transmitter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [4:0]  len = '0;

    logic       busy, x, xv, done, ey;
    logic [7:0] mc;
    logic       busy2, x2, xv2, done2, ey2;
    logic [1:0] mc2;

    sequence_transmitter #(.W(16), .LEN_W(5), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .load(load), .data(data), .len(len),
        .busy(busy), .x(x), .x_valid(xv), .done(done), .expect_y(ey), .match_cnt(mc)
    );

    sequence_transmitter #(.W(16), .LEN_W(5), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .load(load), .data(data), .len(len),
        .busy(busy2), .x(x2), .x_valid(xv2), .done(done2), .expect_y(ey2), .match_cnt(mc2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic x;
        logic ey;
        logic done;
        int   c8;
        int   c2;
    } rec_t;

    rec_t exp_q[$];
    bit   stream[$];
    int   rem = 0;
    int   cnt8 = 0;
    int   cnt2 = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the frame is the last len_eff bits of data, read high to low;
    // a match is any point where the last four bits ever sent read 1,0,1,1.
    task automatic accept_frame(input logic [15:0] d, input int l);
        int le;
        le = (l > 16) ? 16 : l;
        for (int i = le - 1; i >= 0; i--) begin
            rec_t r;
            int   n;
            r.x = d[i];
            stream.push_back(d[i]);
            n = stream.size();
            r.ey = (n >= 4) && stream[n-4] && !stream[n-3] && stream[n-2] && stream[n-1];
            r.done = (i == 0);
            r.c8 = cnt8;
            r.c2 = cnt2;
            if (r.ey) begin
                if (cnt8 < 255) cnt8++;
                if (cnt2 < 3) cnt2++;
            end
            exp_q.push_back(r);
        end
        rem = le;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) begin
            rem = 0;
            cnt8 = 0;
            cnt2 = 0;
            exp_q.delete();
            stream.delete();
        end else if (rem > 0) begin
            rem--;
        end else if (load && len != 0) begin
            accept_frame(data, int'(len));
        end
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic [4:0] l);
        load = 1'b1;
        data = d;
        len  = l;
        step();
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rem != 0 || exp_q.size() != 0) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout pending=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
        step();
        chk("match_cnt_end", 32'(mc), 32'(cnt8));
        chk("match_cnt2_end", 32'(mc2), 32'(cnt2));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 32'(busy), 32'(rem != 0));
            chk("busy2", 32'(busy2), 32'(rem != 0));
            if (xv) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit actual=x_valid=1 expected=x_valid=0 at %0t", $time);
                end else begin
                    rec_t r;
                    r = exp_q.pop_front();
                    chk("x", 32'(x), 32'(r.x));
                    chk("expect_y", 32'(ey), 32'(r.ey));
                    chk("done", 32'(done), 32'(r.done));
                    chk("match_cnt", 32'(mc), 32'(r.c8));
                    chk("x2", 32'(x2), 32'(r.x));
                    chk("expect_y2", 32'(ey2), 32'(r.ey));
                    chk("done2", 32'(done2), 32'(r.done));
                    chk("match_cnt2", 32'(mc2), 32'(r.c2));
                end
            end else begin
                chk("idle_x", 32'(x), 32'd0);
                chk("idle_done", 32'(done), 32'd0);
                chk("idle_expect_y", 32'(ey), 32'd0);
                chk("idle_xv2", 32'(xv2), 32'd0);
            end
        end
    end

    initial begin
        step();
        step();
        mon_en = 1'b1;
        step();
        chk("reset_match_cnt", 32'(mc), 32'd0);
        chk("reset_match_cnt2", 32'(mc2), 32'd0);
        reset = 1'b0;

        // 1011011: matches on bits 4 and 7
        send(16'h005B, 5'd7);
        wait_idle();

        // pattern completes across a frame gap
        do_reset();
        send(16'h0005, 5'd3);
        wait_idle();
        send(16'h0001, 5'd1);
        wait_idle();

        // load held high through a frame
        load = 1'b1;
        data = 16'h000D;
        len  = 5'd4;
        step();
        data = 16'h000B;
        repeat (8) step();
        load = 1'b0;
        wait_idle();

        // len = 0 ignored, oversized len clamped
        load = 1'b1;
        data = 16'hFFFF;
        len  = 5'd0;
        repeat (3) step();
        load = 1'b0;
        send(16'hFFFF, 5'd20);
        wait_idle();

        // reset on the third bit aborts the frame
        send(16'h000B, 5'd4);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_match_cnt", 32'(mc), 32'd0);
        send(16'h000B, 5'd4);
        wait_idle();

        // saturation on the narrow counter
        do_reset();
        send(16'h16DB, 5'd13);
        wait_idle();

        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 29) == 0) begin
                do_reset();
            end else begin
                load = 1'b1;
                data = 16'($urandom);
                len  = 5'($urandom_range(0, 20));
                step();
                load = 1'b0;
                repeat ($urandom_range(0, 6)) step();
            end
        end
        wait_idle();

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
